exception_sequencer: RTL and testbench
======================================

Name: exception_sequencer

Overview:
- Multicycle exception handler between the control unit/ALU/mult_div flags and the PC/EPC registers.
- On an invalid opcode, overflow or divide-by-zero, it captures the faulting PC into EPC and redirects memory addressing to the exception vector byte.
- It then loads the zero-extended vector byte into PC.
- The control unit holds off normal sequencing while `busy` is high.

Parameters:
- `MEM_LAT`, 2: cycles from a stable memory address to valid `mem_rdata`. Legal range 1..7.
- `EPC_OFFSET`, 4: value subtracted from `pc_in` to form EPC, because PC has already been incremented at fetch.
- `VEC_OPCODE`, 253: vector byte address for an invalid opcode.
- `VEC_OVF`, 254: vector byte address for an overflow.
- `VEC_DIV0`, 255: vector byte address for a divide-by-zero.

Ports:
- `clk` input 1: system clock, rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `exc_opcode` input 1: invalid-opcode request, level sampled at `clk`.
- `exc_ovf` input 1: ALU overflow request, already qualified by the control unit for signed ops.
- `exc_div0` input 1: mult_div `div_zero` request.
- `pc_in` input 32: current PC register output.
- `mem_rdata` input 32: memory `Dataout`; only bits [7:0] are used.
- `busy` output 1: high while an exception sequence is in progress.
- `mem_sel` output 1: forces the IorD path to `mem_addr`.
- `mem_addr` output 32: vector byte address.
- `epc_load` output 1: one-cycle load strobe for EPC.
- `epc_value` output 32: EPC data.
- `pc_load` output 1: one-cycle load strobe for PC.
- `pc_value` output 32: new PC, equal to {24'b0, vector byte}.
- `done` output 1: one-cycle pulse, coincident with `pc_load`.

Behaviour:
- **Reset (reset=0, asynchronous):**
  - State goes to IDLE and the wait counter to 0.
  - All outputs are 0, including `mem_addr`, `epc_value` and `pc_value`.
- **States:** IDLE, WAIT, COMMIT.
- **IDLE:**
  - If any request is high at a rising edge (edge E0):
    - Latch the cause. Priority is opcode > ovf > div0; lower-priority simultaneous requests are discarded.
    - Latch `epc_value = pc_in - EPC_OFFSET`, modulo 2^32. Example: `pc_in`=0x00000002 gives 0xFFFFFFFE.
    - Set `mem_addr` to the vector for the cause, set `busy`=1 and `mem_sel`=1, load counter=`MEM_LAT`-1, and go to WAIT.
  - With no request, stay in IDLE with all strobes 0.
- **WAIT:**
  - `mem_addr` and `mem_sel` are held stable.
  - The counter decrements each edge.
  - At the edge where counter==0, capture `pc_value` = {24'b0, `mem_rdata[7:0]`} and go to COMMIT.
  - WAIT therefore lasts exactly `MEM_LAT` cycles.
- **COMMIT (one cycle):**
  - `epc_load`=1, `pc_load`=1, `done`=1, `busy`=1, `mem_sel`=0.
  - On the next edge, go to IDLE and clear `busy`.
- **Latency:**
  - With E0 as the sampling edge, `pc_load` is high during the cycle after edge E0+`MEM_LAT`.
  - `busy` is high for `MEM_LAT`+1 cycles.
- **Requests while busy:** ignored and not queued, because the control unit is stalled. A request held high through COMMIT is re-sampled in IDLE and starts a new sequence. The control unit must drop requests once it sees `busy`.
- **EPC/PC ordering:** `epc_value` is frozen from E0, so the EPC register latches the old PC even though PC is loaded in the same cycle.
- **Reset mid-sequence:** the sequence aborts immediately. No `pc_load` or `epc_load` pulse occurs, and the block returns to IDLE.
- **Outputs:** `mem_addr`, `epc_value` and `pc_value` hold their last values in IDLE, but are only meaningful when qualified by `mem_sel` or the strobes.
- **Registers:** all outputs are registered; there are no combinational paths from input to output.

Optional Feature:
- Macro: `EXC_CAUSE_EN`.
- **Defined:**
  - Adds output `cause` [1:0]: 00 none, 01 opcode, 10 ovf, 11 div0.
  - Adds output `lost` [1:0]: sticky flags set for each lower-priority request discarded at E0. Bit0 = ovf lost, bit1 = div0 lost.
  - `cause` is written at E0 and held until the next exception. `lost` is cleared at E0 of each new exception.
  - Both reset to 0.
- **Undefined:** these ports and registers do not exist, and behaviour is otherwise identical.

Test Plan:
- **Overflow, `MEM_LAT`=2:** `pc_in`=0x00000040, `exc_ovf` pulsed 1 cycle, `mem_rdata[7:0]`=0x9C.
  - `mem_addr`=254 and `mem_sel`=1 for 2 cycles.
  - Then `pc_load`/`epc_load`/`done`=1 for 1 cycle, with `pc_value`=0x0000009C and `epc_value`=0x0000003C.
  - `busy` is high for 3 cycles.
- **Simultaneous requests:** `exc_opcode`, `exc_ovf` and `exc_div0` high together.
  - `mem_addr`=253.
  - With `EXC_CAUSE_EN` defined: `cause`=01 and `lost`=11.
- **Divide-by-zero, `MEM_LAT`=1:** `exc_div0` with `pc_in`=0x00000100 and `mem_rdata`=0xFFFFFF7F.
  - `mem_addr`=255, `pc_value`=0x0000007F, `epc_value`=0x000000FC.
  - `pc_load` occurs 2 cycles after E0.
- **Request during WAIT:** `exc_ovf` at E0, then `exc_div0` pulsed during WAIT.
  - Only one COMMIT occurs, with `mem_addr`=254.
  - No second sequence follows.
- **Reset mid-WAIT:** `reset`=0 asserted asynchronously mid-cycle.
  - All outputs go to 0 immediately, with no `pc_load` pulse.
  - After release, a fresh `exc_opcode` completes normally.
- **EPC wrap:** `pc_in`=0x00000002 with `exc_opcode`.
  - `epc_value`=0xFFFFFFFE.

Source files
------------

// File: rtl/exception_sequencer_if.sv
// exception_sequencer_if: request flags, PC/memory inputs, EPC/PC load outputs.
// Optional EXC_CAUSE_EN adds the cause/lost reporting signals.
interface exception_sequencer_if;
    logic        exc_opcode;
    logic        exc_ovf;
    logic        exc_div0;
    logic [31:0] pc_in;
    logic [31:0] mem_rdata;
    logic        busy;
    logic        mem_sel;
    logic [31:0] mem_addr;
    logic        epc_load;
    logic [31:0] epc_value;
    logic        pc_load;
    logic [31:0] pc_value;
    logic        done;
`ifdef EXC_CAUSE_EN
    logic [1:0]  cause;
    logic [1:0]  lost;
`endif

    modport master (
        output exc_opcode, exc_ovf, exc_div0, pc_in, mem_rdata,
`ifdef EXC_CAUSE_EN
        input  cause, lost,
`endif
        input  busy, mem_sel, mem_addr, epc_load, epc_value,
        input  pc_load, pc_value, done
    );

    modport slave (
        input  exc_opcode, exc_ovf, exc_div0, pc_in, mem_rdata,
`ifdef EXC_CAUSE_EN
        output cause, lost,
`endif
        output busy, mem_sel, mem_addr, epc_load, epc_value,
        output pc_load, pc_value, done
    );
endinterface

// File: rtl/exception_sequencer.sv
// exception_sequencer: saves EPC, fetches the vector byte, loads it into PC.
// Optional macro EXC_CAUSE_EN adds cause/lost reporting registers.
module exception_sequencer #(
    parameter int MEM_LAT    = 2,
    parameter int EPC_OFFSET = 4,
    parameter int VEC_OPCODE = 253,
    parameter int VEC_OVF    = 254,
    parameter int VEC_DIV0   = 255
) (
    input  logic                 clk,
    input  logic                 reset,
    exception_sequencer_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_COMMIT} state_t;

    localparam logic [2:0] CNT_INIT = 3'(MEM_LAT - 1);

    state_t      state;
    logic [2:0]  cnt;
    logic        any_req;
    logic [31:0] vec;

    assign any_req = bus.exc_opcode | bus.exc_ovf | bus.exc_div0;

    // Fixed priority: opcode over overflow over divide-by-zero.
    always_comb begin
        vec = 32'(VEC_DIV0);
        if (bus.exc_opcode)
            vec = 32'(VEC_OPCODE);
        else if (bus.exc_ovf)
            vec = 32'(VEC_OVF);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= S_IDLE;
            cnt           <= '0;
            bus.busy      <= 1'b0;
            bus.mem_sel   <= 1'b0;
            bus.mem_addr  <= '0;
            bus.epc_load  <= 1'b0;
            bus.epc_value <= '0;
            bus.pc_load   <= 1'b0;
            bus.pc_value  <= '0;
            bus.done      <= 1'b0;
`ifdef EXC_CAUSE_EN
            bus.cause     <= 2'b00;
            bus.lost      <= 2'b00;
`endif
        end else begin
            bus.epc_load <= 1'b0;
            bus.pc_load  <= 1'b0;
            bus.done     <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (any_req) begin
                        bus.epc_value <= bus.pc_in - 32'(EPC_OFFSET);
                        bus.mem_addr  <= vec;
                        bus.busy      <= 1'b1;
                        bus.mem_sel   <= 1'b1;
                        cnt           <= CNT_INIT;
                        state         <= S_WAIT;
`ifdef EXC_CAUSE_EN
                        if (bus.exc_opcode)
                            bus.cause <= 2'b01;
                        else if (bus.exc_ovf)
                            bus.cause <= 2'b10;
                        else
                            bus.cause <= 2'b11;
                        bus.lost <= {bus.exc_div0 & (bus.exc_opcode | bus.exc_ovf),
                                     bus.exc_ovf & bus.exc_opcode};
`endif
                    end
                end
                S_WAIT: begin
                    if (cnt == 3'd0) begin
                        bus.pc_value <= {24'h0, bus.mem_rdata[7:0]};
                        bus.mem_sel  <= 1'b0;
                        bus.epc_load <= 1'b1;
                        bus.pc_load  <= 1'b1;
                        bus.done     <= 1'b1;
                        state        <= S_COMMIT;
                    end else begin
                        cnt <= cnt - 3'd1;
                    end
                end
                S_COMMIT: begin
                    bus.busy <= 1'b0;
                    state    <= S_IDLE;
                end
                default: begin
                    bus.busy    <= 1'b0;
                    bus.mem_sel <= 1'b0;
                    state       <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_exception_sequencer.sv
// tb_exception_sequencer: two instances (MEM_LAT 2 and 1) against a
// time-since-fault reference model, directed cases then random traffic.
module tb_exception_sequencer;
    logic        clk = 1'b0;
    logic        reset;
    logic        op, ovf, dz;
    logic [31:0] pc, rdata;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    exception_sequencer_if if0 ();
    exception_sequencer_if if1 ();

    assign if0.exc_opcode = op;
    assign if0.exc_ovf    = ovf;
    assign if0.exc_div0   = dz;
    assign if0.pc_in      = pc;
    assign if0.mem_rdata  = rdata;
    assign if1.exc_opcode = op;
    assign if1.exc_ovf    = ovf;
    assign if1.exc_div0   = dz;
    assign if1.pc_in      = pc;
    assign if1.mem_rdata  = rdata;

    exception_sequencer #(.MEM_LAT(2)) u_dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (if0.slave)
    );

    exception_sequencer #(.MEM_LAT(1)) u_dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (if1.slave)
    );

    // Model: per instance, edges elapsed since the sampling edge E0.
    int          lat [2] = '{2, 1};
    bit          m_active [2];
    int          m_t [2];
    logic [31:0] m_vec [2];
    logic [31:0] m_epc [2];
    logic [31:0] m_pcv [2];
    logic [1:0]  m_cause [2];
    logic [1:0]  m_lost [2];

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_total++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_active[i] = 1'b0;
            m_t[i]      = 0;
            m_vec[i]    = '0;
            m_epc[i]    = '0;
            m_pcv[i]    = '0;
            m_cause[i]  = 2'b00;
            m_lost[i]   = 2'b00;
        end
    endtask

    task automatic model_step();
        if (!reset) begin
            model_reset();
            return;
        end
        for (int i = 0; i < 2; i++) begin
            if (m_active[i]) begin
                m_t[i]++;
                if (m_t[i] == lat[i] + 1)
                    m_pcv[i] = {24'h0, rdata[7:0]};
                if (m_t[i] > lat[i] + 1)
                    m_active[i] = 1'b0;
            end else if (op || ovf || dz) begin
                m_active[i] = 1'b1;
                m_t[i]      = 1;
                m_epc[i]    = pc - 32'd4;
                m_vec[i]    = op ? 32'd253 : (ovf ? 32'd254 : 32'd255);
                m_cause[i]  = op ? 2'd1 : (ovf ? 2'd2 : 2'd3);
                m_lost[i]   = {dz & (op | ovf), ovf & op};
            end
        end
    endtask

    task automatic check_inst(int i, logic busy, logic sel,
                              logic [31:0] addr, logic el,
                              logic [31:0] ev, logic pl,
                              logic [31:0] pv, logic dn);
        logic act, strobe, sel_exp;
        act     = m_active[i];
        sel_exp = act && (m_t[i] <= lat[i]);
        strobe  = act && (m_t[i] == lat[i] + 1);
        check($sformatf("busy%0d", i), 32'(busy), 32'(act));
        check($sformatf("mem_sel%0d", i), 32'(sel), 32'(sel_exp));
        check($sformatf("epc_load%0d", i), 32'(el), 32'(strobe));
        check($sformatf("pc_load%0d", i), 32'(pl), 32'(strobe));
        check($sformatf("done%0d", i), 32'(dn), 32'(strobe));
        check($sformatf("mem_addr%0d", i), addr, m_vec[i]);
        check($sformatf("epc_value%0d", i), ev, m_epc[i]);
        check($sformatf("pc_value%0d", i), pv, m_pcv[i]);
    endtask

    task automatic check_all();
        check_inst(0, if0.busy, if0.mem_sel, if0.mem_addr, if0.epc_load,
                   if0.epc_value, if0.pc_load, if0.pc_value, if0.done);
        check_inst(1, if1.busy, if1.mem_sel, if1.mem_addr, if1.epc_load,
                   if1.epc_value, if1.pc_load, if1.pc_value, if1.done);
`ifdef EXC_CAUSE_EN
        check("cause0", 32'(if0.cause), 32'(m_cause[0]));
        check("lost0", 32'(if0.lost), 32'(m_lost[0]));
        check("cause1", 32'(if1.cause), 32'(m_cause[1]));
        check("lost1", 32'(if1.lost), 32'(m_lost[1]));
`endif
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all();
    endtask

    task automatic idle(int n);
        op = 1'b0; ovf = 1'b0; dz = 1'b0;
        for (int k = 0; k < n; k++)
            cycle();
    endtask

    initial begin
        int pulses;
        reset = 1'b0;
        op = 1'b0; ovf = 1'b0; dz = 1'b0;
        pc = '0; rdata = '0;
        model_reset();
        #1;
        check_all();
        check("rst_busy", 32'(if0.busy), 32'd0);
        cycle();
        cycle();
        reset = 1'b1;
        idle(2);

        // Overflow, latency 2
        pc = 32'h40; rdata = 32'h0000_009C; ovf = 1'b1;
        cycle();
        ovf = 1'b0;
        check("ovf_addr", if0.mem_addr, 32'd254);
        check("ovf_sel_c1", 32'(if0.mem_sel), 32'd1);
        cycle();
        check("ovf_sel_c2", 32'(if0.mem_sel), 32'd1);
        cycle();
        check("ovf_pc_load", 32'(if0.pc_load), 32'd1);
        check("ovf_pc_value", if0.pc_value, 32'h9C);
        check("ovf_epc_value", if0.epc_value, 32'h3C);
        idle(3);

        // Simultaneous requests
        op = 1'b1; ovf = 1'b1; dz = 1'b1;
        cycle();
        check("simul_addr", if0.mem_addr, 32'd253);
`ifdef EXC_CAUSE_EN
        check("simul_cause", 32'(if0.cause), 32'd1);
        check("simul_lost", 32'(if0.lost), 32'd3);
`endif
        idle(4);

        // Divide-by-zero on the latency-1 instance
        pc = 32'h100; rdata = 32'hFFFF_FF7F; dz = 1'b1;
        cycle();
        dz = 1'b0;
        check("div0_addr", if1.mem_addr, 32'd255);
        cycle();
        check("div0_pc_load", 32'(if1.pc_load), 32'd1);
        check("div0_pc_value", if1.pc_value, 32'h7F);
        check("div0_epc_value", if1.epc_value, 32'hFC);
        idle(3);

        // Request arriving while busy is dropped
        pc = 32'h200; rdata = 32'h11; ovf = 1'b1;
        cycle();
        pulses = 0;
        ovf = 1'b0; dz = 1'b1;
        cycle();
        pulses += int'(if0.pc_load);
        dz = 1'b0;
        for (int k = 0; k < 6; k++) begin
            cycle();
            pulses += int'(if0.pc_load);
        end
        check("wait_req_commits", 32'(pulses), 32'd1);
        check("wait_req_addr", if0.mem_addr, 32'd254);

        // Asynchronous reset in the middle of WAIT
        pc = 32'h300; op = 1'b1;
        cycle();
        op = 1'b0;
        #2 reset = 1'b0;
        #1;
        model_reset();
        check_all();
        check("rst_mid_sel", 32'(if0.mem_sel), 32'd0);
        check("rst_mid_addr", if0.mem_addr, 32'd0);
        cycle();
        reset = 1'b1;
        pulses = 0;
        for (int k = 0; k < 3; k++) begin
            cycle();
            pulses += int'(if0.pc_load) + int'(if1.pc_load);
        end
        check("rst_no_pc_load", 32'(pulses), 32'd0);
        pc = 32'h0; rdata = 32'h55; op = 1'b1;
        cycle();
        op = 1'b0;
        cycle();
        cycle();
        check("post_rst_pc_load", 32'(if0.pc_load), 32'd1);
        check("post_rst_pc_value", if0.pc_value, 32'h55);
        idle(3);

        // EPC wrap-around
        pc = 32'h2; op = 1'b1;
        cycle();
        op = 1'b0;
        check("epc_wrap", if0.epc_value, 32'hFFFF_FFFE);
        idle(4);

        // Random traffic, including requests held through COMMIT
        for (int k = 0; k < 500; k++) begin
            op    = ($urandom_range(0, 7) == 0);
            ovf   = ($urandom_range(0, 5) == 0);
            dz    = ($urandom_range(0, 5) == 0);
            pc    = $urandom;
            rdata = $urandom;
            cycle();
        end
        idle(4);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
